// File: rtl/fft_peak_detect.sv
// fft_peak_detect
// Sits behind the 256-point FFT core. It answers the core's done pulse with a
// one-cycle unload, computes re^2+im^2 for every unloaded bin, and keeps the
// strongest bin inside [BIN_LO, BIN_HI]. After each frame it presents one peak
// result to the control logic, which takes it with a valid/ack handshake.
//
// Optional feature (macro FFT_PEAK_THRESH_EN): when defined, an in-band bin
// also needs power >= thresh to count as a peak. When undefined, the thresh
// port is present but ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              act on fft_done (0 = stay in IDLE once the frame is done)
//   fft_done        core done pulse
//   fft_dv          core output beat valid
//   fft_xk_index    bin index of the beat
//   fft_xk_re/im    signed bin value
//   fft_unload      one-cycle unload request to the core
//   thresh          minimum peak power (optional feature only)
//   pow_valid/index/data   per-bin power strobe, bin and re^2+im^2
//   result_valid/ack       peak result handshake
//   peak_bin/pow/found     peak result payload
//   overrun         sticky: a result was overwritten before it was acked
//   timeout_err     sticky: a frame stalled in RECV and was abandoned
module fft_peak_detect #(
  parameter int unsigned NFFT    = 256,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned XK_W    = 23,
  parameter int unsigned BIN_LO  = 1,
  parameter int unsigned BIN_HI  = 127,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fft_done,
  input  logic                   fft_dv,
  input  logic [IDX_W-1:0]       fft_xk_index,
  input  logic signed [XK_W-1:0] fft_xk_re,
  input  logic signed [XK_W-1:0] fft_xk_im,
  output logic                   fft_unload,
  input  logic [2*XK_W-1:0]      thresh,
  output logic                   pow_valid,
  output logic [IDX_W-1:0]       pow_index,
  output logic [2*XK_W-1:0]      pow_data,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [IDX_W-1:0]       peak_bin,
  output logic [2*XK_W-1:0]      peak_pow,
  output logic                   peak_found,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int unsigned POW_W = 2 * XK_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNLOAD,
    S_RECV,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state;
  state_t             state_n;
  logic               unload_n;
  logic               report;
  logic               tmo_hit;
  logic               drain_cnt;
  logic [TMR_W-1:0]   timer;

  // Power pipeline registers (E1: squares, E2: sum on the pow_* outputs)
  logic signed [POW_W-1:0] re_ext;
  logic signed [POW_W-1:0] im_ext;
  logic signed [POW_W-1:0] re_sq;
  logic signed [POW_W-1:0] im_sq;
  logic [POW_W-1:0]        sq_re;
  logic [POW_W-1:0]        sq_im;
  logic                    dv1;
  logic [IDX_W-1:0]        idx1;

  // Running peak for the frame in flight
  logic [POW_W-1:0]        run_max;
  logic [IDX_W-1:0]        run_bin;
  logic                    run_found;
  logic                    track;
  logic                    in_band;
  logic                    qualify;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and per-state strobes
  always_comb begin
    state_n = state;
    report  = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && fft_done) state_n = S_UNLOAD;
      end
      S_UNLOAD: begin
        state_n = S_RECV;
      end
      S_RECV: begin
        if (fft_dv) begin
          if (fft_xk_index == IDX_W'(NFFT - 1)) state_n = S_DRAIN;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt) state_n = S_REPORT;
      end
      S_REPORT: begin
        report  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    unload_n = (state_n == S_UNLOAD);
  end

  // Unload strobe, drain counter and idle-beat timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fft_unload  <= 1'b0;
      drain_cnt   <= 1'b0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      fft_unload  <= unload_n;
      drain_cnt   <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
      if (state == S_RECV && !fft_dv) timer <= timer + TMR_W'(1);
      else                            timer <= '0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // Squares of sign-extended operands; |x|^2 <= 2^(2*XK_W-2) so the signed
  // product is exact and non-negative.
  assign re_ext = POW_W'(fft_xk_re);
  assign im_ext = POW_W'(fft_xk_im);
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;

  // E1 / E2 power pipeline, free-running on dv
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_re     <= '0;
      sq_im     <= '0;
      dv1       <= 1'b0;
      idx1      <= '0;
      pow_valid <= 1'b0;
      pow_index <= '0;
      pow_data  <= '0;
    end else begin
      dv1       <= fft_dv;
      pow_valid <= dv1;
      if (fft_dv) begin
        sq_re <= $unsigned(re_sq);
        sq_im <= $unsigned(im_sq);
        idx1  <= fft_xk_index;
      end
      if (dv1) begin
        pow_data  <= sq_re + sq_im;
        pow_index <= idx1;
      end
    end
  end

  // E3 qualification: in band, strictly above the running max (lowest bin
  // wins ties), and only while a frame is being received or drained.
  assign track   = (state == S_RECV) || (state == S_DRAIN);
  assign in_band = (32'(pow_index) >= BIN_LO) && (32'(pow_index) <= BIN_HI);

`ifdef FFT_PEAK_THRESH_EN
  assign qualify = pow_valid && track && in_band &&
                   (pow_data >= thresh) && (pow_data > run_max);
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign qualify = pow_valid && track && in_band && (pow_data > run_max);
`endif

  // Running peak, cleared as the core is asked to unload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max   <= '0;
      run_bin   <= '0;
      run_found <= 1'b0;
    end else if (state == S_UNLOAD) begin
      run_max   <= '0;
      run_bin   <= '0;
      run_found <= 1'b0;
    end else if (qualify) begin
      run_max   <= pow_data;
      run_bin   <= pow_index;
      run_found <= 1'b1;
    end
  end

  // Result handshake; a new report always wins over a pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      peak_bin     <= '0;
      peak_pow     <= '0;
      peak_found   <= 1'b0;
      overrun      <= 1'b0;
    end else if (report) begin
      result_valid <= 1'b1;
      peak_bin     <= run_bin;
      peak_pow     <= run_max;
      peak_found   <= run_found;
      if (result_valid && !result_ack) overrun <= 1'b1;
    end else if (result_ack) begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect
// Directed frame table plus randomized frames for fft_peak_detect, checked
// against a reference peak search done over whole-frame arrays. Follows the
// FFT_PEAK_THRESH_EN macro for the threshold case.
module tb_fft_peak_detect;

  localparam int unsigned NFFT    = 256;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned XK_W    = 23;
  localparam int unsigned BIN_LO  = 1;
  localparam int unsigned BIN_HI  = 127;
  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned POW_W   = 2 * XK_W;
  localparam int          NV      = 5;

  logic                   clk;
  logic                   rst;
  logic                   en;
  logic                   fft_done;
  logic                   fft_dv;
  logic [IDX_W-1:0]       fft_xk_index;
  logic signed [XK_W-1:0] fft_xk_re;
  logic signed [XK_W-1:0] fft_xk_im;
  logic                   fft_unload;
  logic [POW_W-1:0]       thresh;
  logic                   pow_valid;
  logic [IDX_W-1:0]       pow_index;
  logic [POW_W-1:0]       pow_data;
  logic                   result_valid;
  logic                   result_ack;
  logic [IDX_W-1:0]       peak_bin;
  logic [POW_W-1:0]       peak_pow;
  logic                   peak_found;
  logic                   overrun;
  logic                   timeout_err;

  fft_peak_detect #(
    .NFFT(NFFT), .IDX_W(IDX_W), .XK_W(XK_W),
    .BIN_LO(BIN_LO), .BIN_HI(BIN_HI), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .fft_done(fft_done), .fft_dv(fft_dv), .fft_xk_index(fft_xk_index),
    .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im), .fft_unload(fft_unload),
    .thresh(thresh),
    .pow_valid(pow_valid), .pow_index(pow_index), .pow_data(pow_data),
    .result_valid(result_valid), .result_ack(result_ack),
    .peak_bin(peak_bin), .peak_pow(peak_pow), .peak_found(peak_found),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  typedef struct packed { int bin; int re; int im; } spec_t;
  typedef struct packed {
    int               bg_re;
    int               bg_im;
    logic [POW_W-1:0] th;
    int               e_bin;
    longint           e_pow;
    logic             e_found;
  } vec_t;
  typedef struct { logic [IDX_W-1:0] idx; longint pw; } pexp_t;

  vec_t                   tab    [NV];
  spec_t                  sp_tab [NV][4];
  string                  names  [NV];
  logic signed [XK_W-1:0] fr_re  [NFFT];
  logic signed [XK_W-1:0] fr_im  [NFFT];
  pexp_t                  exp_q  [$];
  int                     n_vec = 0;
  int                     n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  function automatic longint bin_pow(input int k);
    return longint'(fr_re[k]) * longint'(fr_re[k]) + longint'(fr_im[k]) * longint'(fr_im[k]);
  endfunction

  // Reference peak: strongest in-band bin, first one wins on equal power
  function automatic void ref_peak(output int bin, output longint pw, output logic found);
    bin = 0; pw = 0; found = 1'b0;
    for (int k = int'(BIN_LO); k <= int'(BIN_HI); k++) begin
      longint p;
      bit     ok;
      p  = bin_pow(k);
      ok = (p > pw);
`ifdef FFT_PEAK_THRESH_EN
      ok = ok && (p >= longint'(thresh));
`endif
      if (ok) begin
        bin = k; pw = p; found = 1'b1;
      end
    end
  endfunction

  // Per-beat power monitor
  always @(negedge clk) begin : mon
    pexp_t e;
    if (!rst && pow_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pow_unexpected: got beat for bin %0d, expected none", pow_index);
      end else begin
        e = exp_q.pop_front();
        chk("pow_index", 64'(pow_index), 64'(e.idx));
        chk("pow_data", 64'(pow_data), 64'(e.pw));
      end
    end
  end

  task automatic run_frame(input int nbeats, input bit gaps, input bit mid_done);
    int    g;
    pexp_t pe;
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("unload_pulse", 64'(fft_unload), 64'd1);
    tick();
    chk("unload_single", 64'(fft_unload), 64'd0);
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        fft_dv = 1'b0;
        repeat (g) tick();
      end
      fft_dv       = 1'b1;
      fft_xk_index = IDX_W'(k);
      fft_xk_re    = fr_re[k];
      fft_xk_im    = fr_im[k];
      fft_done     = mid_done && (k == 50);
      pe.idx = IDX_W'(k);
      pe.pw  = bin_pow(k);
      exp_q.push_back(pe);
      tick();
      if (mid_done && k == 50) chk("done_ignored", 64'(fft_unload), 64'd0);
    end
    fft_dv   = 1'b0;
    fft_done = 1'b0;
  endtask

  // Result appears on the 4th edge counting the one that samples the last beat
  task automatic wait_result(input bit check_lat, input bit ack_rep);
    tick();
    tick();
    if (check_lat) chk("result_latency", 64'(result_valid), 64'd0);
    if (ack_rep) result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("result_valid", 64'(result_valid), 64'd1);
  endtask

  task automatic chk_result(input int e_bin, input longint e_pow, input logic e_found);
    chk("peak_bin", 64'(peak_bin), 64'(e_bin));
    chk("peak_pow", 64'(peak_pow), 64'(e_pow));
    chk("peak_found", 64'(peak_found), 64'(e_found));
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    chk("ack_clears", 64'(result_valid), 64'd0);
  endtask

  task automatic chk_all_zero();
    chk("rst_unload", 64'(fft_unload), 64'd0);
    chk("rst_pow_valid", 64'(pow_valid), 64'd0);
    chk("rst_pow_index", 64'(pow_index), 64'd0);
    chk("rst_pow_data", 64'(pow_data), 64'd0);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_peak_bin", 64'(peak_bin), 64'd0);
    chk("rst_peak_pow", 64'(peak_pow), 64'd0);
    chk("rst_peak_found", 64'(peak_found), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
  endtask

  function automatic void fill_random(input int mode);
    int v;
    for (int k = 0; k < int'(NFFT); k++) begin
      if (mode == 0) begin
        fr_re[k] = XK_W'($urandom);
        fr_im[k] = XK_W'($urandom);
      end else begin
        v = int'($urandom_range(0, 2000)) - 1000; fr_re[k] = XK_W'(v);
        v = int'($urandom_range(0, 2000)) - 1000; fr_im[k] = XK_W'(v);
      end
      if ($urandom_range(0, 9) == 0) begin
        fr_re[k] = '0;
        fr_im[k] = '0;
      end
    end
  endfunction

  int     r_bin;
  longint r_pow;
  logic   r_found;

  initial begin
    // Directed frame table
    for (int v = 0; v < NV; v++)
      for (int j = 0; j < 4; j++) sp_tab[v][j] = '{bin: -1, re: 0, im: 0};

    names[0] = "single_peak";
    tab[0] = '{bg_re: 1, bg_im: 1, th: '0, e_bin: 10, e_pow: 64'd5000000, e_found: 1'b1};
    sp_tab[0][0] = '{bin: 10, re: 1000, im: -2000};

    names[1] = "tie_dc_oob";
    tab[1] = '{bg_re: 1, bg_im: 1, th: '0, e_bin: 20, e_pow: 64'd5000, e_found: 1'b1};
    sp_tab[1][0] = '{bin: 0,   re: 4000000, im: 0};
    sp_tab[1][1] = '{bin: 20,  re: 70,      im: 10};
    sp_tab[1][2] = '{bin: 40,  re: -50,     im: 50};
    sp_tab[1][3] = '{bin: 200, re: 3000,    im: 0};

    names[2] = "zero_band";
    tab[2] = '{bg_re: 0, bg_im: 0, th: '0, e_bin: 0, e_pow: 64'd0, e_found: 1'b0};
    sp_tab[2][0] = '{bin: 0,   re: 5, im: 5};
    sp_tab[2][1] = '{bin: 128, re: 7, im: 0};

    names[3] = "thresh";
`ifdef FFT_PEAK_THRESH_EN
    tab[3] = '{bg_re: 1, bg_im: 1, th: 46'd10000000, e_bin: 0, e_pow: 64'd0, e_found: 1'b0};
`else
    tab[3] = '{bg_re: 1, bg_im: 1, th: 46'd10000000, e_bin: 10, e_pow: 64'd5000000, e_found: 1'b1};
`endif
    sp_tab[3][0] = '{bin: 10, re: 1000, im: -2000};

    names[4] = "band_edges_fullscale";
    tab[4] = '{bg_re: 0, bg_im: 1, th: '0, e_bin: 127, e_pow: 64'd35184372088832, e_found: 1'b1};
    sp_tab[4][0] = '{bin: 1,   re: 100,      im: 0};
    sp_tab[4][1] = '{bin: 127, re: -4194304, im: -4194304};
    sp_tab[4][2] = '{bin: 128, re: -4194304, im: -4194304};

    rst = 1'b1; en = 1'b0; fft_done = 1'b0; fft_dv = 1'b0; fft_xk_index = '0;
    fft_xk_re = '0; fft_xk_im = '0; thresh = '0; result_ack = 1'b0;
    tick();
    tick();
    chk_all_zero();
    rst = 1'b0;
    tick();

    // en=0: done is not answered
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    chk("en_off_no_unload", 64'(fft_unload), 64'd0);
    tick();
    en = 1'b1;

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < int'(NFFT); k++) begin
        fr_re[k] = XK_W'(tab[v].bg_re);
        fr_im[k] = XK_W'(tab[v].bg_im);
      end
      for (int j = 0; j < 4; j++)
        if (sp_tab[v][j].bin >= 0) begin
          fr_re[sp_tab[v][j].bin] = XK_W'(sp_tab[v][j].re);
          fr_im[sp_tab[v][j].bin] = XK_W'(sp_tab[v][j].im);
        end
      thresh = tab[v].th;
      run_frame(int'(NFFT), 1'b0, 1'b0);
      wait_result(1'b1, 1'b0);
      if (peak_bin !== IDX_W'(tab[v].e_bin)) $display("  in frame %s", names[v]);
      chk_result(tab[v].e_bin, tab[v].e_pow, tab[v].e_found);
      chk("no_overrun", 64'(overrun), 64'd0);
      do_ack();
    end
    thresh = '0;

    // Randomized frames against the reference search
    for (int r = 0; r < 4; r++) begin
      fill_random(r % 2);
      ref_peak(r_bin, r_pow, r_found);
      run_frame(int'(NFFT), 1'b1, r == 1);
      wait_result(1'b1, 1'b0);
      chk_result(r_bin, r_pow, r_found);
      do_ack();
    end

    // Handshake: ack coinciding with report, then overwrite without ack
    fill_random(1);
    run_frame(int'(NFFT), 1'b0, 1'b0);
    wait_result(1'b1, 1'b0);
    fill_random(1);
    ref_peak(r_bin, r_pow, r_found);
    run_frame(int'(NFFT), 1'b0, 1'b0);
    wait_result(1'b0, 1'b1);
    chk("ack_at_report_no_overrun", 64'(overrun), 64'd0);
    chk_result(r_bin, r_pow, r_found);
    fill_random(0);
    ref_peak(r_bin, r_pow, r_found);
    run_frame(int'(NFFT), 1'b0, 1'b0);
    wait_result(1'b0, 1'b0);
    chk("overrun_set", 64'(overrun), 64'd1);
    chk_result(r_bin, r_pow, r_found);
    do_ack();

    // Stall after 100 beats: abort after exactly TIMEOUT idle cycles
    fill_random(1);
    run_frame(100, 1'b0, 1'b0);
    repeat (TIMEOUT - 1) tick();
    chk("timeout_not_yet", 64'(timeout_err), 64'd0);
    tick();
    chk("timeout_err", 64'(timeout_err), 64'd1);
    tick();
    tick();
    chk("timeout_no_result", 64'(result_valid), 64'd0);
    fill_random(0);
    ref_peak(r_bin, r_pow, r_found);
    run_frame(int'(NFFT), 1'b0, 1'b0);
    wait_result(1'b1, 1'b0);
    chk_result(r_bin, r_pow, r_found);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);

    // Reset mid-frame (result still pending, sticky flags set)
    fill_random(0);
    run_frame(128, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk_all_zero();
    tick();
    rst = 1'b0;
    tick();
    fill_random(1);
    ref_peak(r_bin, r_pow, r_found);
    run_frame(int'(NFFT), 1'b0, 1'b0);
    wait_result(1'b1, 1'b0);
    chk_result(r_bin, r_pow, r_found);
    chk("post_rst_overrun", 64'(overrun), 64'd0);
    chk("post_rst_timeout", 64'(timeout_err), 64'd0);
    do_ack();

    tick();
    tick();
    chk("pow_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the 256-point FFT core (clk/start/unload/done/dv/xk_index/xk_re/xk_im interface, 23-bit signed outputs).
- Drives the core's `unload` on `done` and takes the unloaded bins.
- Computes per-bin power re²+im² and tracks the strongest bin inside a configurable band.
- Presents one peak result per frame to the control logic with a valid/ack handshake.

Parameters:
- NFFT, 256, transform length; bins per frame.
- IDX_W, 8, width of xk_index; must equal log2(NFFT).
- XK_W, 23, width of xk_re/xk_im (signed two's complement).
- BIN_LO, 1, lowest bin considered for the peak (inclusive; default skips DC).
- BIN_HI, 127, highest bin considered (inclusive; default is positive half).
- TIMEOUT, 1023, max cycles in RECV without a dv beat before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  1 = act on FFT done; 0 = stay/return IDLE after current frame
- fft_done  in  1  core done pulse
- fft_dv  in  1  core output data valid
- fft_xk_index  in  IDX_W  bin index of current output
- fft_xk_re  in  XK_W  real part, signed
- fft_xk_im  in  XK_W  imaginary part, signed
- fft_unload  out  1  one-cycle unload request to core
- thresh  in  2*XK_W  minimum power for a valid peak (used only with the optional feature)
- pow_valid  out  1  per-bin power strobe
- pow_index  out  IDX_W  bin of pow_data
- pow_data  out  2*XK_W  re²+im², unsigned
- result_valid  out  1  peak result pending
- result_ack  in  1  consumer accepts result
- peak_bin  out  IDX_W  bin of maximum power
- peak_pow  out  2*XK_W  maximum power
- peak_found  out  1  at least one in-band bin qualified
- overrun  out  1  sticky: result overwritten before ack
- timeout_err  out  1  sticky: RECV timed out

Behaviour:
- Reset (async, rst=1): all outputs 0; FSM to IDLE; peak registers, beat counter and timer cleared. Reset mid-frame discards the partial frame; no result is issued.
- FSM states:
  - IDLE: when en=1 and fft_done=1, go to UNLOAD.
  - UNLOAD: fft_unload=1 for exactly one cycle; clear running max and peak_found; go to RECV.
  - RECV: each cycle fft_dv=1 is one beat. Beat with fft_xk_index==NFFT-1 goes to DRAIN. Timer resets on every beat; reaching TIMEOUT sets timeout_err and returns to IDLE with no result.
  - DRAIN: wait 2 cycles for the pipeline to empty; go to REPORT.
  - REPORT: latch result and set result_valid; go to IDLE.
- fft_done while not in IDLE is ignored.
- Power pipeline (free-running on dv, independent of FSM state except that peak tracking only happens in RECV/DRAIN):
  - E1 = edge sampling the beat: register re*re and im*im. Signed XK_W×XK_W products, each ≤ 2^(2*XK_W-2), held unsigned.
  - E2: pow_data = sum (2*XK_W bits; cannot overflow); pow_valid=1 with pow_index.
  - E3: peak compare. Bin must satisfy BIN_LO ≤ index ≤ BIN_HI and pow > running max (strict >, so the lowest bin wins ties). If it qualifies, update max and bin and set peak_found.
  - Running max initialises to 0, so a zero-power band gives peak_found=0 with peak_bin=0.
- result_valid rises on the cycle after E3 of the final beat (4 cycles after the last beat is sampled).
- Handshake:
  - result_valid stays high until result_ack=1 is sampled; it clears on that edge.
  - If REPORT occurs while result_valid=1 and result_ack=0: new result overwrites the old one, result_valid stays 1, overrun is set.
  - If REPORT and result_ack coincide: new result loaded, result_valid stays 1, no overrun.
- Sticky flags (overrun, timeout_err) clear only on rst.
- Beats with indices out of order are accepted as-is. Frame end is detected solely by index NFFT-1.

Optional Feature:
- Macro: FFT_PEAK_THRESH_EN.
- Defined: an in-band bin qualifies only if pow ≥ thresh and pow > running max. peak_found=0 if no bin reaches thresh; result_valid is still issued, with peak_bin=0 and peak_pow=0.
- Undefined: the thresh port exists but is ignored. peak_found=1 whenever any in-band bin has nonzero power.

Test Plan:
1. Reset then en=1 and fft_done pulse -> fft_unload high exactly 1 cycle in the next cycle. Feed 256 beats: bin 10 = (re=1000, im=-2000), all others (1,1) -> result_valid 4 cycles after index 255; peak_bin=10, peak_pow=5000000, peak_found=1.
2. Equal power 5000 at bins 20 and 40, plus bin 0 = (4000000,0) -> peak_bin=20 (tie goes to lower bin); DC (bin 0) excluded. Bin 200 = (3000,0) is out of band -> ignored.
3. Two frames back-to-back, no result_ack -> overrun=1 and second frame's result shown. Then ack concurrent with a third REPORT -> result_valid stays 1, no new overrun.
4. Stop dv after 100 beats -> timeout_err=1 after 1023 idle cycles, FSM back in IDLE, no result_valid. The next done/frame completes normally.
5. Assert rst at beat 128, release, run a full frame -> result reflects only the new frame; all outputs 0 during reset.
6. With FFT_PEAK_THRESH_EN defined, thresh=10^7 and max in-band power 5·10^6 -> result_valid=1, peak_found=0, peak_bin=0. Without the macro, same stimulus -> peak_found=1.
